// File: rtl/tap_seq.sv
// tap_seq: tap-tempo sequencer.
// Measures the interval between debounced taps in time-base ticks, sends each
// accepted period to an external period-to-BPM converter and registers the
// tempo it returns. A tap arriving while the converter is busy is parked in a
// one-deep pending slot and sent as soon as the converter answers.
// Optional feature: define TAP_AVERAGE_EN to send the mean of the last four
// accepted periods instead of the latest one.
module tap_seq #(
    parameter int PER_WIDTH = 16,
    parameter int BPM_WIDTH = 9,
    parameter int PER_MIN   = 240,
    parameter int PER_MAX   = 4000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tp_i,
    input  logic                 btn_i,
    output logic [PER_WIDTH-1:0] btn_per_o,
    output logic                 btn_per_valid_o,
    input  logic [BPM_WIDTH-1:0] bpm_i,
    input  logic                 bpm_valid_i,
    output logic [BPM_WIDTH-1:0] bpm_o,
    output logic                 bpm_valid_o
);

    localparam logic [PER_WIDTH-1:0] PER_MIN_C = PER_WIDTH'(PER_MIN);
    localparam logic [PER_WIDTH-1:0] PER_MAX_C = PER_WIDTH'(PER_MAX);
    localparam logic [PER_WIDTH-1:0] ONE_C     = PER_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PER_WIDTH-1:0] cnt_q, cnt_d;
    logic [PER_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_v_q, pend_v_d;
    logic [PER_WIDTH-1:0] per_q, per_d;
    logic                 req_q, req_d;
    logic [BPM_WIDTH-1:0] bpm_q, bpm_d;
    logic                 bpmv_q, bpmv_d;

    logic                 at_max_s;
    logic                 btn_qual_s;
    logic                 issue_s;
    logic [PER_WIDTH-1:0] issue_per_s;
    logic [PER_WIDTH-1:0] send_per_s;

    // The tap compares against the pre-increment count, so a same-cycle tick
    // never turns a too-short interval into an accepted one.
    assign at_max_s   = (cnt_q >= PER_MAX_C);
    assign btn_qual_s = btn_i && (cnt_q >= PER_MIN_C) && !at_max_s;

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            per_q    <= '0;
            req_q    <= 1'b0;
            bpm_q    <= '0;
            bpmv_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            per_q    <= per_d;
            req_q    <= req_d;
            bpm_q    <= bpm_d;
            bpmv_q   <= bpmv_d;
        end
    end

    // Next-state selection; timeout has priority over every other event.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_i) begin
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (at_max_s) begin
                    state_d = ST_IDLE;
                end else if (btn_qual_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_WAIT: begin
                if (at_max_s) begin
                    state_d = ST_IDLE;
                end else if (bpm_valid_i) begin
                    if (btn_qual_s || pend_v_q) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter, pending slot, converter request and tempo register updates.
    always_comb begin
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        issue_s     = 1'b0;
        issue_per_s = cnt_q;
        bpm_d       = bpm_q;
        bpmv_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                pend_v_d = 1'b0;
            end
            ST_COUNT: begin
                if (at_max_s) begin
                    cnt_d = '0;
                end else if (btn_qual_s) begin
                    cnt_d   = '0;
                    issue_s = 1'b1;
                end else if (tp_i) begin
                    cnt_d = cnt_q + ONE_C;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT: begin
                if (at_max_s) begin
                    cnt_d    = '0;
                    pend_v_d = 1'b0;
                end else begin
                    if (btn_qual_s) begin
                        cnt_d = '0;
                    end else if (tp_i) begin
                        cnt_d = cnt_q + ONE_C;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (bpm_valid_i) begin
                        bpm_d  = bpm_i;
                        bpmv_d = 1'b1;
                        if (btn_qual_s) begin
                            issue_s  = 1'b1;
                            pend_v_d = 1'b0;
                        end else if (pend_v_q) begin
                            issue_s     = 1'b1;
                            issue_per_s = pend_q;
                            pend_v_d    = 1'b0;
                        end else begin
                            issue_s = 1'b0;
                        end
                    end else if (btn_qual_s) begin
                        pend_d   = cnt_q;
                        pend_v_d = 1'b1;
                    end else begin
                        pend_v_d = pend_v_q;
                    end
                end
            end
            default: begin
                cnt_d    = '0;
                pend_v_d = 1'b0;
            end
        endcase
        req_d = issue_s;
        if (issue_s) begin
            per_d = send_per_s;
        end else begin
            per_d = per_q;
        end
    end

`ifdef TAP_AVERAGE_EN
    logic [3:0][PER_WIDTH-1:0] hist_q, hist_d;
    logic                      hist_v_q, hist_v_d;
    logic                      clear_hist_s;

    // Mean of four periods, truncated.
    function automatic logic [PER_WIDTH-1:0] mean4(input logic [3:0][PER_WIDTH-1:0] h);
        logic [PER_WIDTH+1:0] s;
        s = {2'b00, h[0]} + {2'b00, h[1]} + {2'b00, h[2]} + {2'b00, h[3]};
        return s[PER_WIDTH+1:2];
    endfunction

    assign clear_hist_s = (state_q != ST_IDLE) && at_max_s;

    // History shift; the first period after a timeout fills all four slots.
    always_comb begin
        hist_d   = hist_q;
        hist_v_d = hist_v_q;
        if (clear_hist_s) begin
            hist_v_d = 1'b0;
        end else if (issue_s) begin
            if (hist_v_q) begin
                hist_d = {hist_q[2:0], issue_per_s};
            end else begin
                hist_d = {4{issue_per_s}};
            end
            hist_v_d = 1'b1;
        end else begin
            hist_v_d = hist_v_q;
        end
        send_per_s = mean4(hist_d);
    end

    // History registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q   <= '0;
            hist_v_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            hist_v_q <= hist_v_d;
        end
    end
`else
    // Without averaging the accepted period is sent unchanged.
    always_comb begin
        send_per_s = issue_per_s;
    end
`endif

    assign btn_per_o       = per_q;
    assign btn_per_valid_o = req_q;
    assign bpm_o           = bpm_q;
    assign bpm_valid_o     = bpmv_q;

endmodule

// File: doc/tap_seq.md
TAP_SEQ -- requirements
Module: tap_seq

Interface
REQ-001 SHALL have parameter PER_WIDTH, default 16, width of the tap period in tp_i ticks.
REQ-002 SHALL have parameter BPM_WIDTH, default 9, width of the BPM value.
REQ-003 SHALL have parameter PER_MIN, default 240, shortest accepted period in ticks (250 BPM at 1 ms tick).
REQ-004 SHALL have parameter PER_MAX, default 4000, timeout in ticks.
REQ-005 SHALL have port clk_i  in  1  system clock; single clock domain.
REQ-006 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port tp_i  in  1  one-cycle time-base tick (1 ms).
REQ-008 SHALL have port btn_i  in  1  one-cycle debounced tap pulse.
REQ-009 SHALL have port btn_per_o  out  PER_WIDTH  period sent to the per2bpm converter.
REQ-010 SHALL have port btn_per_valid_o  out  1  one-cycle request pulse to the converter.
REQ-011 SHALL have port bpm_i  in  BPM_WIDTH  converter result.
REQ-012 SHALL have port bpm_valid_i  in  1  one-cycle converter done pulse.
REQ-013 SHALL have port bpm_o  out  BPM_WIDTH  registered tempo.
REQ-014 SHALL have port bpm_valid_o  out  1  one-cycle pulse when bpm_o updates.

Function
REQ-015 SHALL implement states IDLE (no reference tap), COUNT (measuring), WAIT (converter busy).
REQ-016 IDLE: btn_i SHALL clear the period counter and enter COUNT; no request issued.
REQ-017 COUNT: counter SHALL increment by 1 on each tp_i, saturating at PER_MAX.
REQ-018 COUNT: btn_i with counter < PER_MIN SHALL be ignored; counter keeps running.
REQ-019 COUNT: btn_i with PER_MIN <= counter < PER_MAX SHALL latch the counter as the new period, clear the counter, and enter WAIT.
REQ-020 The cycle after entering WAIT, btn_per_valid_o SHALL pulse for exactly one cycle; btn_per_o SHALL hold the (averaged) period stable from that cycle until bpm_valid_i.
REQ-021 WAIT: bpm_valid_i SHALL load bpm_i into bpm_o and pulse bpm_valid_o on the following cycle; next state COUNT.
REQ-022 Counter reaching PER_MAX in COUNT or WAIT SHALL force IDLE and clear averaging history; bpm_o holds its last value.
REQ-023 WAIT: counter SHALL keep running; a qualifying btn_i (per REQ-019) SHALL be stored in a one-deep pending register; later taps overwrite it.
REQ-024 On bpm_valid_i with a pending period, the block SHALL issue it (REQ-020) instead of entering COUNT.
REQ-025 bpm_valid_i outside WAIT SHALL be ignored.
REQ-026 btn_i and tp_i in the same cycle: the tap SHALL see the pre-increment counter.

Reset
REQ-027 rst_i SHALL asynchronously force IDLE and clear the counter, pending, history, btn_per_o, btn_per_valid_o, bpm_o and bpm_valid_o to 0.
REQ-028 Reset during WAIT SHALL abandon the request; a late bpm_valid_i SHALL be ignored (REQ-025).

Configuration
REQ-029 With macro TAP_AVERAGE_EN defined, the period sent SHALL be the mean of the last 4 accepted periods (sum PER_WIDTH+2 bits, shifted right 2, truncated); the first period after IDLE fills all 4 slots.
REQ-030 Without TAP_AVERAGE_EN, the period sent SHALL be the latest accepted period; no history storage is built.

Verification
REQ-031 Taps every 500 tp_i, converter answers 120 -> btn_per_o=500 pulse per tap, bpm_o=120, one bpm_valid_o per answer.
REQ-032 Tap 100 ticks after a reference tap, then another at 500 ticks -> first ignored, btn_per_o=500.
REQ-033 No tap for 4000 ticks after a reference tap -> IDLE, next tap issues no request, bpm_o unchanged.
REQ-034 Periods 400,400,400,600 after IDLE -> last btn_per_o=450 with TAP_AVERAGE_EN, 600 without.
REQ-035 Tap at 300 ticks while converter stalled in WAIT -> after bpm_valid_i, btn_per_valid_o pulses with btn_per_o=300 (no averaging build).
REQ-036 rst_i asserted mid-WAIT, then bpm_valid_i=1 with bpm_i=99 -> all outputs 0, bpm_o stays 0.
